// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: 8-way round-robin arbiter with go strobe, held grant and hold-limit timeout
module rr_grant_arbiter #(
   parameter int N        = 8,
   parameter int PTR_W    = 3,
   parameter int MAX_HOLD = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N-1:0]     req,
   input  logic             go,
   output logic [N-1:0]     grant,
   output logic             grant_vld,
   output logic [PTR_W-1:0] ptr,
   output logic             forced
);
   localparam int CW = $clog2(MAX_HOLD + 1);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t           state_q;
   logic [N-1:0]     grant_q;
   logic             vld_q;
   logic             forced_q;
   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] w_q;
   logic [CW-1:0]    cnt_q;
   logic [PTR_W-1:0] win_d;
   logic             found_d;
   // first set request scanning from ptr upward with wrap; descending loop lets the nearest one win
   always_comb begin
      win_d   = '0;
      found_d = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[ptr_q + PTR_W'(i)]) begin
            win_d   = ptr_q + PTR_W'(i);
            found_d = 1'b1;
         end
      end
   end
   // arbitration FSM: grant in IDLE on go, hold in BUSY until release or hold limit
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         vld_q    <= 1'b0;
         forced_q <= 1'b0;
         ptr_q    <= '0;
         w_q      <= '0;
         cnt_q    <= '0;
      end else begin
         forced_q <= 1'b0;
         if (state_q == IDLE) begin
            if (go && found_d) begin
               grant_q <= {{(N-1){1'b0}}, 1'b1} << win_d;
               vld_q   <= 1'b1;
               w_q     <= win_d;
               cnt_q   <= CW'(1);
               state_q <= BUSY;
            end
         end else if (!req[w_q] || cnt_q == CW'(MAX_HOLD)) begin
            grant_q  <= '0;
            vld_q    <= 1'b0;
            ptr_q    <= w_q + PTR_W'(1);
            forced_q <= req[w_q];
            state_q  <= IDLE;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end
   assign grant     = grant_q;
   assign grant_vld = vld_q;
   assign ptr       = ptr_q;
   assign forced    = forced_q;
endmodule
